cnu_sched: RTL and testbench



---
 rtl/cnu_pkg.sv | 16 +
 rtl/sched_pipe.sv | 28 ++
 rtl/cnu_sched.sv | 152 +++++++++++++++
 tb/tb_cnu_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnu_pkg.sv
// Shared definitions for the check-node row scheduler: FSM encoding and
// delay-line entry layout (valid in bit 0, row address above it).
package cnu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned ENTRY_VLD      = 0;
  localparam int unsigned ENTRY_ADDR_LSB = 1;

endpackage

// File: rtl/sched_pipe.sv
// Valid/address shift register; stage 0 is loaded every cycle, the
// last stage is the oldest entry.
module sched_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [WIDTH-1:0]            entry_i,
  output logic [DEPTH-1:0][WIDTH-1:0] stage_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= entry_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/cnu_sched.sv
// Flooding-schedule row scheduler for the CNU. Optional early termination
// on satisfied parity is enabled with `define CNU_SCHED_EARLY_TERM_EN.
module cnu_sched
  import cnu_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned MAX_ITER = 10,
  parameter int unsigned CNU_LAT  = 2,
  parameter int unsigned row_w    = 2,
  parameter int unsigned iter_w   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic              row_ok,
  output logic              rd_en,
  output logic [row_w-1:0]  rd_addr,
  output logic              cnu_en,
  output logic              wr_en,
  output logic [row_w-1:0]  wr_addr,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [iter_w-1:0] iter_cnt,
  output state_e            dbg_state,
  output logic              dbg_parity
);

  localparam int unsigned DEPTH = 1 + CNU_LAT;
  localparam int unsigned EW    = row_w + 1;

  state_e              state_q, state_d;
  logic [row_w-1:0]    row_q, row_d;
  logic [iter_w-1:0]   iter_q, iter_d;
  logic                acc_q, acc_d;
  logic                conv_q, conv_d;

  logic [EW-1:0]            entry;
  logic [DEPTH-1:0][EW-1:0] stages;
  logic                     inflight;
  logic                     last_iter;
  logic                     early_term;

  assign entry = {(rd_en ? row_q : {row_w{1'b0}}), rd_en};

  sched_pipe #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_pipe (
    .clk_i   (clk),
    .rst_ni  (rst),
    .entry_i (entry),
    .stage_o (stages)
  );

  assign cnu_en  = stages[0][ENTRY_VLD];
  assign wr_en   = stages[DEPTH-1][ENTRY_VLD];
  assign wr_addr = stages[DEPTH-1][EW-1:ENTRY_ADDR_LSB];

  // The last stage may be writing this cycle; only younger entries keep DRAIN busy.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      inflight = inflight | stages[i][ENTRY_VLD];
    end
  end

  assign last_iter = ((iter_q + iter_w'(1)) == iter_w'(MAX_ITER));

`ifdef CNU_SCHED_EARLY_TERM_EN
  assign early_term = acc_q;
`else
  assign early_term = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    iter_d  = iter_q;
    acc_d   = wr_en ? (acc_q & row_ok) : acc_q;
    conv_d  = conv_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          row_d   = '0;
          iter_d  = '0;
          acc_d   = 1'b1;
          conv_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (!hold) begin
          rd_en = 1'b1;
          if (row_q == row_w'(ROWS - 1)) begin
            row_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            row_d = row_q + row_w'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        iter_d = iter_q + iter_w'(1);
        if (last_iter || early_term) begin
          state_d = ST_DONE;
`ifdef CNU_SCHED_EARLY_TERM_EN
          conv_d  = acc_q;
`else
          conv_d  = 1'b0;
`endif
        end else begin
          state_d = ST_ISSUE;
          row_d   = '0;
          acc_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      iter_q  <= '0;
      acc_q   <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      iter_q  <= iter_d;
      acc_q   <= acc_d;
      conv_q  <= conv_d;
    end
  end

  assign rd_addr    = row_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign converged  = conv_q;
  assign iter_cnt   = iter_q;
  assign dbg_state  = state_q;
  assign dbg_parity = acc_q;

endmodule

// File: tb/tb_cnu_sched.sv
// Directed bench for cnu_sched with ROWS=4, CNU_LAT=2, MAX_ITER=3; cycle 1 is
// the cycle right after the edge that samples start.
module tb_cnu_sched;
  import cnu_pkg::*;

  localparam int unsigned ROWS     = 4;
  localparam int unsigned MAX_ITER = 3;
  localparam int unsigned CNU_LAT  = 2;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned ITER_W   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic              row_ok = 1'b0;
  logic              rd_en, cnu_en, wr_en, busy, done, converged, dbg_parity;
  logic [ROW_W-1:0]  rd_addr, wr_addr;
  logic [ITER_W-1:0] iter_cnt;
  state_e            dbg_state;

  cnu_sched #(
    .ROWS     (ROWS),
    .MAX_ITER (MAX_ITER),
    .CNU_LAT  (CNU_LAT),
    .row_w    (ROW_W),
    .iter_w   (ITER_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hold       (hold),
    .row_ok     (row_ok),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .cnu_en     (cnu_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .iter_cnt   (iter_cnt),
    .dbg_state  (dbg_state),
    .dbg_parity (dbg_parity)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int gcyc = 0;
  int base = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor: event logs keyed by cycle*16+addr ----------------
  logic [31:0] act_rd_q[$], act_wr_q[$], act_cnu_q[$], act_chk_q[$], done_q[$];
  logic [31:0] exp_q[$], cmp_q[$];
  int busy_n = 0;

  always @(negedge clk) begin
    if (rd_en)  act_rd_q.push_back(32'((gcyc - base + 1) * 16) + 32'(rd_addr));
    if (wr_en)  act_wr_q.push_back(32'((gcyc - base + 1) * 16) + 32'(wr_addr));
    if (cnu_en) act_cnu_q.push_back(32'(gcyc - base + 1));
    if (dbg_state == ST_CHECK) act_chk_q.push_back(32'(gcyc - base + 1));
    if (done)   done_q.push_back(32'(gcyc - base + 1));
    if (busy)   busy_n++;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_run(input string tag);
    check_val({tag, "_count"}, 32'(cmp_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && cmp_q.size() > 0) begin
      check_val(tag, cmp_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    cmp_q.delete();
  endtask

  function automatic logic [31:0] first_done();
    return (done_q.size() > 0) ? done_q[0] : 32'hffff_ffff;
  endfunction

  task automatic clear_logs();
    act_rd_q.delete(); act_wr_q.delete(); act_cnu_q.delete();
    act_chk_q.delete(); done_q.delete(); busy_n = 0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_strobes"}, {26'd0, rd_en, cnu_en, wr_en, busy, done, converged}, 32'd0);
    check_val({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check_val({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check_val({tag, "_iter_cnt"}, 32'(iter_cnt), 32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic launch();
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    base  = gcyc;
    start = 1'b0;
  endtask

  // Drives cycles 1..n; hold/row_ok/start apply to the cycle index c.
  task automatic drive(input int n, input logic [63:0] hold_mask, input bit ok_dflt,
                       input int bad_cyc, input int s1, input int s2, input int s3);
    for (int c = 1; c <= n; c++) begin
      hold   = (c < 64) ? hold_mask[c] : 1'b0;
      row_ok = ok_dflt && (c != bad_cyc);
      start  = (c == s1) || (c == s2) || (c == s3);
      @(posedge clk);
      #1;
    end
    hold   = 1'b0;
    row_ok = 1'b0;
    start  = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #2 rst = 1'b0;
    #3;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic three-iteration decode, parity never satisfied.
    launch();
    drive(30, 64'd0, 1'b0, -1, -1, -1, -1);
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < 4; r++) exp_q.push_back(32'((1 + 8 * i + r) * 16 + r));
    cmp_q = act_rd_q;
    sb_run("basic_rd");
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < 4; r++) exp_q.push_back(32'((4 + 8 * i + r) * 16 + r));
    cmp_q = act_wr_q;
    sb_run("basic_wr");
    for (int c = 2; c <= 5; c++) exp_q.push_back(32'(c));
    cmp_q = act_cnu_q[0:3];
    sb_run("basic_cnu");
    exp_q = '{32'd8, 32'd16, 32'd24};
    cmp_q = act_chk_q;
    sb_run("basic_check");
    check_val("basic_done", first_done(), 32'd25);
    check_val("basic_busy_cycles", 32'(busy_n), 32'd25);
    check_val("basic_iter_cnt", 32'(iter_cnt), 32'd3);
    check_val("basic_converged", 32'(converged), 32'd0);

    // Hold in cycles 2-3 of the first iteration.
    launch();
    drive(30, 64'h0C, 1'b0, -1, -1, -1, -1);
    exp_q = '{32'(1*16+0), 32'(4*16+1), 32'(5*16+2), 32'(6*16+3)};
    cmp_q = act_rd_q[0:3];
    sb_run("hold_rd");
    exp_q = '{32'(4*16+0), 32'(7*16+1), 32'(8*16+2), 32'(9*16+3)};
    cmp_q = act_wr_q[0:3];
    sb_run("hold_wr");
    check_val("hold_first_check", act_chk_q.size() > 0 ? act_chk_q[0] : 32'hffff_ffff, 32'd10);
    check_val("hold_second_rd", act_rd_q.size() > 4 ? act_rd_q[4] : 32'hffff_ffff, 32'(11*16));
    check_val("hold_done", first_done(), 32'd27);

    // start while busy (cycle 5) and in the DONE cycle (25) ignored; 26 accepted.
    launch();
    drive(55, 64'd0, 1'b0, -1, 5, 25, 26);
    check_val("restart_done0", first_done(), 32'd25);
    check_val("restart_rd_count", 32'(act_rd_q.size()), 32'd24);
    check_val("restart_rd12", act_rd_q.size() > 12 ? act_rd_q[12] : 32'hffff_ffff, 32'(27*16));
    check_val("restart_done1", done_q.size() > 1 ? done_q[1] : 32'hffff_ffff, 32'd51);
    check_val("restart_busy_cycles", 32'(busy_n), 32'd50);

`ifdef CNU_SCHED_EARLY_TERM_EN
    launch();
    drive(15, 64'd0, 1'b1, -1, -1, -1, -1);
    check_val("early_ok_done", first_done(), 32'd9);
    check_val("early_ok_iter", 32'(iter_cnt), 32'd1);
    check_val("early_ok_conv", 32'(converged), 32'd1);

    launch();
    drive(25, 64'd0, 1'b1, 6, -1, -1, -1);
    check_val("early_bad_done", first_done(), 32'd17);
    check_val("early_bad_iter", 32'(iter_cnt), 32'd2);
    check_val("early_bad_conv", 32'(converged), 32'd1);
`else
    launch();
    drive(30, 64'd0, 1'b1, -1, -1, -1, -1);
    check_val("noearly_done", first_done(), 32'd25);
    check_val("noearly_iter", 32'(iter_cnt), 32'd3);
    check_val("noearly_conv", 32'(converged), 32'd0);
`endif

    // Reset mid-write in cycle 6 (row 2 being written).
    launch();
    drive(5, 64'd0, 1'b0, -1, -1, -1, -1);
    check_val("midrst_wr_en", 32'(wr_en), 32'd1);
    check_val("midrst_wr_addr", 32'(wr_addr), 32'd2);
    #1 rst = 1'b0;
    #1;
    check_idle("midrst");
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    drive(20, 64'd0, 1'b0, -1, -1, -1, -1);
    check_val("postrst_wr_count", 32'(act_wr_q.size()), 32'd0);
    check_val("postrst_rd_count", 32'(act_rd_q.size()), 32'd0);
    check_val("postrst_busy_cycles", 32'(busy_n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
